// File: rtl/clk_lock_monitor.sv
// clk_lock_monitor
//   Reset sequencer behind the clock manager. It synchronizes the async
//   `locked` status and waits until lock has been continuously stable for
//   STABLE_CYCLES cycles. It then releases the debug reset, and releases the
//   core reset DBG_LEAD cycles after that. A lock drop after release
//   re-asserts both resets, sets a sticky flag and bumps a saturating counter.
//
// Ports
//   clk        in   system clock
//   reset      in   synchronous active-high reset
//   locked     in   clock manager lock status (asynchronous to clk)
//   clr_fault  in   pulse: clears lock_lost / drop_count
//   dbg_reset  out  debug-domain reset, active high (registered)
//   sys_reset  out  core reset, active high (registered)
//   ready      out  high only while in RUN (registered)
//   lock_lost  out  sticky lock-drop flag
//   drop_count out  saturating count of lock drops after release
module clk_lock_monitor #(
    parameter int STABLE_CYCLES = 1024,
    parameter int DBG_LEAD      = 16,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             locked,
    input  logic             clr_fault,
    output logic             dbg_reset,
    output logic             sys_reset,
    output logic             ready,
    output logic             lock_lost,
    output logic [CNT_W-1:0] drop_count
);

    localparam int MAXC = (STABLE_CYCLES > DBG_LEAD) ? STABLE_CYCLES : DBG_LEAD;
    localparam int CW   = (MAXC > 2) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] LEAD_LAST   = CW'(DBG_LEAD - 1);

    typedef enum logic [1:0] {S_WAIT, S_STABLE, S_DBG, S_RUN} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          s1, s2;
    logic          drop;

    // Only a loss of lock after debug reset has been released is a fault;
    // losing lock while still qualifying in STABLE just restarts the window.
    assign drop = !s2 && (state == S_DBG || state == S_RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_WAIT;
            cnt        <= '0;
            s1         <= 1'b0;
            s2         <= 1'b0;
            dbg_reset  <= 1'b1;
            sys_reset  <= 1'b1;
            ready      <= 1'b0;
            lock_lost  <= 1'b0;
            drop_count <= '0;
        end else begin
            s1 <= locked;
            s2 <= s1;

            case (state)
                S_WAIT: begin
                    if (s2) begin
                        state <= S_STABLE;
                        cnt   <= '0;
                    end
                end
                S_STABLE: begin
                    if (!s2) begin
                        state <= S_WAIT;
                        cnt   <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        state     <= S_DBG;
                        cnt       <= '0;
                        dbg_reset <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DBG: begin
                    if (!s2) begin
                        state     <= S_WAIT;
                        cnt       <= '0;
                        dbg_reset <= 1'b1;
                    end else if (cnt == LEAD_LAST) begin
                        state     <= S_RUN;
                        cnt       <= '0;
                        sys_reset <= 1'b0;
                        ready     <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_RUN: begin
                    if (!s2) begin
                        state     <= S_WAIT;
                        dbg_reset <= 1'b1;
                        sys_reset <= 1'b1;
                        ready     <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_WAIT;
                    cnt       <= '0;
                    dbg_reset <= 1'b1;
                    sys_reset <= 1'b1;
                    ready     <= 1'b0;
                end
            endcase

            // Clear takes effect before a same-cycle drop is counted.
            if (clr_fault) begin
                lock_lost  <= drop;
                drop_count <= drop ? CNT_W'(1) : '0;
            end else if (drop) begin
                lock_lost <= 1'b1;
                if (drop_count != '1)
                    drop_count <= drop_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/clk_lock_monitor.md
# clk_lock_monitor

Reset sequencer sitting directly downstream of the clock manager wrapper. It watches the clock manager's asynchronous `locked` status and holds the debug logic and the core in reset until lock has been continuously stable. It then releases debug reset first and core reset a fixed number of cycles later. On any loss of lock it re-asserts both resets immediately and records the event in a sticky flag and a saturating counter, readable by debug logic.

## Interface

Parameters:
- `STABLE_CYCLES`, default 1024: consecutive synchronized-locked cycles required before release; legal values are 2 or more.
- `DBG_LEAD`, default 16: cycles between `dbg_reset` release and `sys_reset` release; legal values are 1 or more.
- `CNT_W`, default 8: width of `drop_count`.

Ports:
- `clk`  in  1  system clock (`clk_out1` domain of the clock manager).
- `reset`  in  1  synchronous, active-high; all state returns to reset values on the next rising edge of `clk`.
- `locked`  in  1  clock manager lock status; asynchronous to `clk`.
- `clr_fault`  in  1  single-cycle pulse; clears `lock_lost` and `drop_count`.
- `dbg_reset`  out  1  active-high reset for the debug domain; registered.
- `sys_reset`  out  1  active-high reset for the core; registered.
- `ready`  out  1  high only in RUN; registered.
- `lock_lost`  out  1  sticky; set on a lock drop after release.
- `drop_count`  out  CNT_W  count of lock drops after release; saturates at all-ones.

## Operation

- `locked` passes through a 2-flop synchronizer (`s1`, `s2`); `locked_s` = `s2`. Both flops reset to 0.
- States: WAIT, STABLE, DBG, RUN. One down-counter or up-counter `cnt`, sized to max(STABLE_CYCLES, DBG_LEAD).
- WAIT:
  - Outputs: `dbg_reset`=1, `sys_reset`=1, `ready`=0.
  - If `locked_s`=1, go to STABLE with `cnt`=0.
- STABLE:
  - Outputs: resets are held at 1.
  - If `locked_s`=0, go to WAIT and clear `cnt`. This is NOT a drop event.
  - Else if `cnt`==STABLE_CYCLES-1, go to DBG with `cnt`=0.
  - Else increment `cnt`.
- DBG:
  - Outputs: `dbg_reset`=0, `sys_reset`=1.
  - If `locked_s`=0, this is a drop event; go to WAIT.
  - Else if `cnt`==DBG_LEAD-1, go to RUN.
  - Else increment `cnt`.
- RUN:
  - Outputs: both resets are 0, `ready`=1.
  - If `locked_s`=0, this is a drop event; go to WAIT.
- Outputs are registered and updated on the same edge as the state, so they always match the current state.
- Drop event:
  - `lock_lost` is set to 1.
  - `drop_count` increments, holding at 2^CNT_W-1.
- `clr_fault` clears `lock_lost` and sets `drop_count` to 0.
  - If a drop event occurs in the same cycle, the clear applies first and the increment second: result `lock_lost`=1, `drop_count`=1.
- Reset values: state WAIT, `cnt`=0, `s1`=`s2`=0, `dbg_reset`=1, `sys_reset`=1, `ready`=0, `lock_lost`=0, `drop_count`=0.

## Timing

- Number rising edges from E1, the first edge at which `locked`=1 is sampled into `s1`, with `locked` held high.
  - `locked_s` goes high after E2.
  - State is STABLE after E3.
  - `dbg_reset` falls on edge E(STABLE_CYCLES+3).
  - `sys_reset` falls and `ready` rises on edge E(STABLE_CYCLES+DBG_LEAD+3).
  - With default parameters: E1027 and E1043.
- Lock loss in DBG or RUN: if `locked`=0 is first sampled at edge F1, both resets are 1 and `ready`=0 after F3. `lock_lost` and `drop_count` update on the same edge F3.
- `locked` low pulses shorter than one `clk` period may be missed; this is acceptable.
- Lock loss in STABLE restarts the full STABLE_CYCLES window; no partial credit is kept.
- `reset` asserted in any state: the next edge forces reset values, including clearing the counters and the synchronizer. Sequencing restarts from WAIT after `reset` deasserts.
- While `reset`=1, `clr_fault` and `locked` are ignored.

## Test plan

Run all scenarios with STABLE_CYCLES=8, DBG_LEAD=4, CNT_W=2.

- Power-up: hold `reset` for 3 cycles, then raise `locked` before edge E1. Expect `dbg_reset` to fall at E11 and `sys_reset` to fall and `ready` to rise at E15. `lock_lost`=0 and `drop_count`=0 throughout.
- Unstable lock: raise `locked` for 5 cycles, drop it for 2 cycles, then raise it again. Expect no release during the first window. Release follows the full E11/E15 timing counted from the second rise. `drop_count` stays 0.
- Drop in RUN: drop `locked` for 4 cycles. Expect both resets high and `ready` low at F3, `lock_lost`=1, `drop_count`=1. A full re-sequence follows when `locked` returns.
- Drop in DBG: drop `locked` 2 cycles after `dbg_reset` falls. Expect `dbg_reset` back to 1 at F3, `sys_reset` never falls, `drop_count` increments.
- Saturation and clear: cause 5 drops after release. Expect `drop_count`=3. Then pulse `clr_fault` on the same edge as a 6th drop event. Expect `drop_count`=1 and `lock_lost`=1.
- Reset mid-operation: assert `reset` for 1 cycle while in RUN. The next edge must show `dbg_reset`=1, `sys_reset`=1, `ready`=0, `lock_lost`=0, `drop_count`=0. With `locked` held high, the resets then re-release at the E11/E15 timing counted from the first post-reset edge.
